// File: rtl/lsu_hs.sv
// Load/store unit with valid/ready handshakes toward the core and the memory bus.
// Misaligned accesses are optionally split into two NB-aligned beats.
module lsu_hs #(
    parameter int unsigned XLEN             = 32,
    parameter bit          SPLIT_MISALIGNED = 1'b1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic            mem_req,
    input  logic            mem_gnt,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_we,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_err
);

    localparam int unsigned NB = XLEN / 8;
    localparam int unsigned OW = $clog2(NB);
    localparam int unsigned BW = 2 * NB;

    typedef enum logic [2:0] {StIdle, StReq1, StWait1, StReq2, StWait2, StResp} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [XLEN-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
    logic [1:0]      size_q, size_d;
    logic            we_q, we_d, uns_q, uns_d, err_q, err_d;

    logic [OW-1:0]     req_off, off_q;
    logic [4:0]        req_bytes, bytes_q;
    logic              req_cross, cross_q;
    logic [8:0]        lo_mask;
    logic [BW-1:0]     be_wide;
    logic [2*XLEN-1:0] wd_wide;
    logic [XLEN-1:0]   aligned, merged, shifted, ext;
    logic [7:0]        ext_bits, ext_sh;

    assign req_off   = req_addr[OW-1:0];
    assign req_bytes = 5'd1 << req_size;
    assign req_cross = (5'(req_off) + req_bytes) > 5'(NB);

    assign off_q   = addr_q[OW-1:0];
    assign bytes_q = 5'd1 << size_q;
    assign cross_q = (5'(off_q) + bytes_q) > 5'(NB);
    assign aligned = {addr_q[XLEN-1:OW], {OW{1'b0}}};

    // Both beats' lanes come from one double-width shift; the upper half is beat 2.
    assign lo_mask = (9'd1 << bytes_q) - 9'd1;
    assign be_wide = BW'(lo_mask) << off_q;
    assign wd_wide = {{XLEN{1'b0}}, wdata_q} << {off_q, 3'b000};

    // Beat 2 sits above beat 1, so one right shift extracts the addressed bytes.
    assign merged   = XLEN'({rd2_q, rd1_q} >> {off_q, 3'b000});
    assign ext_bits = {bytes_q, 3'b000};
    assign ext_sh   = (ext_bits < 8'(XLEN)) ? 8'(XLEN) - ext_bits : 8'd0;
    assign shifted  = merged << ext_sh;
    assign ext      = uns_q ? (shifted >> ext_sh) : XLEN'($signed(shifted) >>> ext_sh);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            size_q  <= size_d;
            we_q    <= we_d;
            uns_q   <= uns_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd1_d     = rd1_q;
        rd2_d     = rd2_q;
        size_d    = size_q;
        we_d      = we_q;
        uns_d     = uns_q;
        err_d     = err_q;
        req_ready = (state_q == StIdle) && rstn;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        mem_req   = 1'b0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_wdata = '0;

        unique case (state_q)
            StIdle: begin
                if (req_valid && req_ready) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    size_d  = req_size;
                    we_d    = req_we;
                    uns_d   = req_unsigned;
                    rd1_d   = '0;
                    rd2_d   = '0;
                    if ((req_size == 2'd3 && XLEN == 32) || (req_cross && !SPLIT_MISALIGNED)) begin
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else begin
                        err_d   = 1'b0;
                        state_d = StReq1;
                    end
                end
            end
            StReq1: begin
                mem_req   = 1'b1;
                mem_addr  = aligned;
                mem_we    = we_q;
                mem_be    = be_wide[NB-1:0];
                mem_wdata = wd_wide[XLEN-1:0];
                if (mem_gnt) state_d = StWait1;
            end
            StWait1: begin
                if (mem_rvalid) begin
                    rd1_d = mem_rdata;
                    if (mem_err) begin
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else if (cross_q) begin
                        state_d = StReq2;
                    end else begin
                        state_d = StResp;
                    end
                end
            end
            StReq2: begin
                mem_req   = 1'b1;
                mem_addr  = aligned + XLEN'(NB);
                mem_we    = we_q;
                mem_be    = be_wide[BW-1:NB];
                mem_wdata = wd_wide[2*XLEN-1:XLEN];
                if (mem_gnt) state_d = StWait2;
            end
            StWait2: begin
                if (mem_rvalid) begin
                    rd2_d   = mem_rdata;
                    err_d   = mem_err;
                    state_d = StResp;
                end
            end
            StResp: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                rsp_rdata = (we_q || err_q) ? '0 : ext;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_lsu_hs.sv
// Directed bench for lsu_hs (XLEN=32): split-enabled main instance plus a split-disabled one.
module tb_lsu_hs;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0, req_valid0 = 1'b0;
    logic        req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0, mem_err = 1'b0;
    logic [31:0] mem_rdata = '0;

    logic        req_ready, rsp_valid, rsp_err, mem_req, mem_we;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        req_ready0, rsp_valid0, rsp_err0, mem_req0, mem_we0;
    logic [31:0] rsp_rdata0, mem_addr0, mem_wdata0;
    logic [3:0]  mem_be0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    lsu_hs #(.XLEN(32), .SPLIT_MISALIGNED(1'b1)) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_req(mem_req), .mem_gnt(mem_gnt),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err)
    );

    lsu_hs #(.XLEN(32), .SPLIT_MISALIGNED(1'b0)) dut0 (
        .clk(clk), .rstn(rstn), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid0),
        .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0), .mem_req(mem_req0), .mem_gnt(mem_gnt),
        .mem_addr(mem_addr0), .mem_we(mem_we0), .mem_be(mem_be0), .mem_wdata(mem_wdata0),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic to_dut0);
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        if (to_dut0) req_valid0 = 1'b1; else req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; req_valid0 = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        @(negedge clk); @(negedge clk);
        vectors++;
        if ({req_ready, rsp_valid, rsp_err, mem_req, mem_we} !== 5'b0 || mem_be !== 4'h0 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0 || rsp_rdata !== 32'h0) begin
            $display("FAIL reset_outputs: got ready=%b rv=%b mreq=%b be=%h addr=%h, want all 0",
                     req_ready, rsp_valid, mem_req, mem_be, mem_addr);
            miscompares++;
        end
        rstn = 1'b1;
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1) begin
            $display("FAIL reset_ready: got %b want 1", req_ready); miscompares++;
        end
    endtask

    task automatic test_load_byte(input logic uns, input logic [31:0] exp);
        issue(1'b0, 2'd0, uns, 32'h103, 32'h0, 1'b0);
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_be !== 4'b1000 || mem_we !== 1'b0) begin
            $display("FAIL lb_beat: got req=%b addr=%h be=%b we=%b want 1 100 1000 0",
                     mem_req, mem_addr, mem_be, mem_we);
            miscompares++;
        end
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        vectors++;
        if (mem_req !== 1'b0) begin
            $display("FAIL lb_wait_req: got %b want 0", mem_req); miscompares++;
        end
        mem_rvalid = 1'b1; mem_rdata = 32'h80AABBCC;
        @(negedge clk);
        mem_rvalid = 1'b0;
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== exp) begin
            $display("FAIL lb_rsp: got v=%b e=%b d=%h want 1 0 %h", rsp_valid, rsp_err, rsp_rdata, exp);
            miscompares++;
        end
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            $display("FAIL lb_pulse: got v=%b ready=%b want 0 1", rsp_valid, req_ready);
            miscompares++;
        end
    endtask

    task automatic test_store_wait();
        issue(1'b1, 2'd1, 1'b0, 32'h202, 32'h1234, 1'b0);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h200 || mem_be !== 4'b1100 ||
                mem_wdata !== 32'h12340000 || mem_we !== 1'b1) begin
                $display("FAIL sh_hold%0d: got req=%b addr=%h be=%b wd=%h we=%b want 1 200 1100 12340000 1",
                         i, mem_req, mem_addr, mem_be, mem_wdata, mem_we);
                miscompares++;
            end
            if (i == 3) mem_gnt = 1'b1;
            else begin
                mem_rvalid = 1'b1;
                mem_rdata  = 32'hDEADBEEF;
            end
            @(negedge clk);
            mem_rvalid = 1'b0;
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
            $display("FAIL sh_rsp: got v=%b e=%b d=%h want 1 0 0", rsp_valid, rsp_err, rsp_rdata);
            miscompares++;
        end
        @(negedge clk);
    endtask

    task automatic test_split_load();
        issue(1'b0, 2'd2, 1'b0, 32'h0FE, 32'h0, 1'b0);
        vectors++;
        if (mem_addr !== 32'h0FC || mem_be !== 4'b1100) begin
            $display("FAIL lw_split_b1: got addr=%h be=%b want 0fc 1100", mem_addr, mem_be);
            miscompares++;
        end
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDDCC1111;
        @(negedge clk);
        mem_rvalid = 1'b0;
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_be !== 4'b0011) begin
            $display("FAIL lw_split_b2: got req=%b addr=%h be=%b want 1 100 0011",
                     mem_req, mem_addr, mem_be);
            miscompares++;
        end
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h2222BBAA;
        vectors++;
        if (rsp_valid !== 1'b0) begin
            $display("FAIL lw_split_early: got rsp_valid=%b want 0", rsp_valid); miscompares++;
        end
        @(negedge clk);
        mem_rvalid = 1'b0;
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'hBBAADDCC) begin
            $display("FAIL lw_split_rsp: got v=%b e=%b d=%h want 1 0 bbaaddcc",
                     rsp_valid, rsp_err, rsp_rdata);
            miscompares++;
        end
        @(negedge clk);
    endtask

    task automatic test_error_requests();
        issue(1'b0, 2'd2, 1'b0, 32'h001, 32'h0, 1'b1);
        vectors++;
        if (mem_req0 !== 1'b0 || rsp_valid0 !== 1'b1 || rsp_err0 !== 1'b1 || rsp_rdata0 !== 32'h0) begin
            $display("FAIL nosplit_err: got req=%b v=%b e=%b d=%h want 0 1 1 0",
                     mem_req0, rsp_valid0, rsp_err0, rsp_rdata0);
            miscompares++;
        end
        @(negedge clk);
        issue(1'b0, 2'd3, 1'b0, 32'h000, 32'h0, 1'b0);
        vectors++;
        if (mem_req !== 1'b0 || rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
            $display("FAIL size3_err: got req=%b v=%b e=%b d=%h want 0 1 1 0",
                     mem_req, rsp_valid, rsp_err, rsp_rdata);
            miscompares++;
        end
        @(negedge clk);
    endtask

    task automatic test_split_store_err();
        issue(1'b1, 2'd2, 1'b0, 32'h0FE, 32'hAABBCCDD, 1'b0);
        vectors++;
        if (mem_be !== 4'b1100 || mem_wdata !== 32'hCCDD0000 || mem_addr !== 32'h0FC) begin
            $display("FAIL sw_err_b1: got be=%b wd=%h addr=%h want 1100 ccdd0000 0fc",
                     mem_be, mem_wdata, mem_addr);
            miscompares++;
        end
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_err = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0; mem_err = 1'b0;
        vectors++;
        if (mem_req !== 1'b0 || rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
            $display("FAIL sw_err_rsp: got req=%b v=%b e=%b d=%h want 0 1 1 0",
                     mem_req, rsp_valid, rsp_err, rsp_rdata);
            miscompares++;
        end
        @(negedge clk);
        vectors++;
        if (mem_req !== 1'b0 || req_ready !== 1'b1) begin
            $display("FAIL sw_err_idle: got req=%b ready=%b want 0 1", mem_req, req_ready);
            miscompares++;
        end
    endtask

    task automatic test_reset_mid();
        issue(1'b0, 2'd2, 1'b0, 32'h010, 32'h0, 1'b0);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        rstn = 1'b0;
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b0 || mem_req !== 1'b0 || req_ready !== 1'b0) begin
            $display("FAIL rst_mid: got v=%b req=%b ready=%b want 0 0 0", rsp_valid, mem_req, req_ready);
            miscompares++;
        end
        rstn = 1'b1;
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            $display("FAIL rst_ready: got ready=%b v=%b want 1 0", req_ready, rsp_valid);
            miscompares++;
        end
        issue(1'b0, 2'd1, 1'b0, 32'h012, 32'h0, 1'b0);
        vectors++;
        if (mem_addr !== 32'h010 || mem_be !== 4'b1100) begin
            $display("FAIL rst_next_beat: got addr=%h be=%b want 010 1100", mem_addr, mem_be);
            miscompares++;
        end
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h80010000;
        @(negedge clk);
        mem_rvalid = 1'b0;
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hFFFF8001) begin
            $display("FAIL rst_next_rsp: got v=%b d=%h want 1 ffff8001", rsp_valid, rsp_rdata);
            miscompares++;
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_load_byte(1'b0, 32'hFFFFFF80);
        test_load_byte(1'b1, 32'h00000080);
        test_store_wait();
        test_split_load();
        test_error_requests();
        test_split_store_err();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lsu_hs.md
Name: lsu_hs

Overview:
- Parametrised load/store unit with a valid/ready request/response handshake on both the core side and the memory side.
- Successor to the single-cycle core's combinational LSU path. Generalised to XLEN 32/64.
- Adds wait-state tolerance, bus-error reporting and optional splitting of misaligned accesses into two aligned beats.
- Sits between the execute stage (address from the ALU, store data from rs2) and the data memory / bus.

Parameters:
- XLEN, 32, data/address width; legal values 32 or 64. NB = XLEN/8 byte lanes.
- SPLIT_MISALIGNED, 1, 1: accesses crossing an NB-aligned boundary are split into two beats; 0: such accesses return an error.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- req_valid  in  1  core request valid
- req_ready  out  1  LSU can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double (legal only when XLEN=64)
- req_unsigned  in  1  zero-extend load result
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data, right-aligned
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  XLEN  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned-unsupported, illegal size, or bus error
- mem_req  out  1  memory request valid
- mem_gnt  in  1  memory accepts the request this cycle
- mem_addr  out  XLEN  NB-aligned address
- mem_we  out  1  write enable
- mem_be  out  NB  byte enables
- mem_wdata  out  XLEN  lane-shifted store data
- mem_rvalid  in  1  beat completion (loads and stores)
- mem_rdata  in  XLEN  read data
- mem_err  in  1  bus error, qualified by mem_rvalid

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low. rstn low at a clock edge sets state IDLE and clears all registers.
- Reset values of outputs:
  - req_ready = 0 while rstn = 0, otherwise 1 in IDLE.
  - rsp_valid, rsp_err, rsp_rdata, mem_req, mem_we, mem_be, mem_addr, mem_wdata all 0.
- States: IDLE, REQ1, WAIT1, REQ2, WAIT2, RESP.
- Request acceptance:
  - req_ready = (state == IDLE) && rstn. Requests are accepted only when req_valid && req_ready.
  - At acceptance, latch addr, size, we, unsigned and wdata.
  - Compute offset = addr mod NB and bytes = 1 << size.
  - cross = offset + bytes > NB.
- IDLE transitions on acceptance:
  - size == 3 with XLEN = 32, or cross with SPLIT_MISALIGNED = 0 -> RESP with err = 1 (no memory access).
  - Otherwise -> REQ1.
- REQ1 / REQ2 (memory request phase):
  - mem_req = 1, and mem_addr, mem_we, mem_be, mem_wdata are held stable until mem_gnt.
  - REQ1 goes to WAIT1 on mem_gnt; REQ2 goes to WAIT2 on mem_gnt.
- Beat 1 contents:
  - mem_addr = addr with the low log2(NB) bits cleared.
  - mem_be = ((1 << bytes) - 1) << offset, truncated to NB bits.
  - mem_wdata = wdata << (8 * offset).
- Beat 2 contents (split accesses only):
  - mem_addr = beat-1 address + NB, wrapping modulo 2^XLEN.
  - mem_be = remaining low lanes.
  - mem_wdata = upper bytes of wdata placed in lane 0 upward.
- WAIT1 / WAIT2 (waiting for beat completion):
  - mem_req = 0. Wait any number of cycles for mem_rvalid.
  - On mem_rvalid && mem_err -> RESP with err = 1, abandoning any remaining beat.
  - On mem_rvalid in WAIT1 with cross -> REQ2, capturing the low part of the data.
  - Otherwise -> RESP with merged data.
- RESP:
  - rsp_valid = 1 for exactly one cycle, then -> IDLE.
  - Load data: extract the bytes (merging beat 2 above beat 1), then sign- or zero-extend from 8·bytes to XLEN.
  - Stores and errors: rsp_rdata = 0.
- Latency, zero wait states (gnt in the request cycle, rvalid the next cycle):
  - Aligned access: accept at cycle 0, mem_req at 1, rvalid at 2, rsp_valid at 3.
  - Split access: rsp_valid at 5.
  - Pure-error requests: rsp_valid at cycle 1.
- Ignored inputs: mem_rvalid outside WAIT states; req_valid while not ready.
- Ordering: only one transaction is outstanding at a time.
- Reset mid-operation: the transaction is dropped with no rsp_valid, and mem_req is 0 from the next cycle. The memory is reset by the same rstn.

Test Plan:
- XLEN=32: load byte 0x80 at addr 0x103, mem_rdata 0x80AABBCC -> mem_be 4'b1000, mem_addr 0x100; rsp_rdata 0xFFFFFF80 at cycle 3. Repeat with unsigned -> 0x00000080.
- XLEN=32: store half 0x1234 at 0x202, mem_gnt delayed 3 cycles -> mem_req held with mem_addr 0x200, be 4'b1100, wdata 0x12340000 stable until gnt; rsp_valid, rsp_rdata 0.
- SPLIT=1: load word at 0x0FE; beat 1 returns 0xDDCCxxxx, beat 2 returns 0xxxxxBBAA -> mem_be 1100 then 0011, addresses 0x0FC and 0x100; rsp_rdata 0xBBAADDCC at cycle 5.
- SPLIT=0: word at 0x001 -> no mem_req; rsp_valid with rsp_err = 1 at cycle 1. Same response for size 3 when XLEN=32.
- mem_err on beat 1 of a split store -> no second mem_req; rsp_err = 1, rsp_rdata 0.
- rstn low while in WAIT1 -> no rsp_valid; req_ready = 1 the cycle after rstn returns high; the next request completes normally.
